// File: rtl/irq_dispatch_ctrl_pkg.sv
// Shared types and constants for the interrupt dispatcher: FSM states,
// default geometry and the priority used when nothing is in service.
package irq_dispatch_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int PRIO_W_DEF  = 2;
    localparam int ID_W_DEF    = $clog2(NUM_SRC_DEF);

    // Running level reported while no source is in service.
    localparam int NONE_PRIO = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/irq_dispatch_ctrl_if.sv
// Consumer-facing bundle: configuration writes, offer handshake and EOI.
// The dispatcher takes the slave side, the consumer the master side.
interface irq_dispatch_ctrl_if
    import irq_dispatch_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PRIO_W  = PRIO_W_DEF,
    parameter int ID_W    = $clog2(NUM_SRC)
);
    logic              cfg_we;
    logic [ID_W-1:0]   cfg_id;
    logic [PRIO_W-1:0] cfg_prio;
    logic              cfg_en;
    logic              irq_valid;
    logic [ID_W-1:0]   irq_id;
    logic [PRIO_W-1:0] irq_prio;
    logic              irq_ack;
    logic              eoi;
    logic [ID_W-1:0]   eoi_id;

    modport master (
        output cfg_we, cfg_id, cfg_prio, cfg_en, irq_ack, eoi, eoi_id,
        input  irq_valid, irq_id, irq_prio
    );

    modport slave (
        input  cfg_we, cfg_id, cfg_prio, cfg_en, irq_ack, eoi, eoi_id,
        output irq_valid, irq_id, irq_prio
    );
endinterface

// File: rtl/irq_dispatch_ctrl_prio_select.sv
// Combinational maximum-priority search over a mask; ties resolve to the
// lowest index because only a strictly greater priority replaces the winner.
module irq_prio_select #(
    parameter int N      = 4,
    parameter int PRIO_W = 2,
    parameter int ID_W   = $clog2(N)
) (
    input  logic [N-1:0]             mask,
    input  logic [N-1:0][PRIO_W-1:0] prio,
    output logic                     found,
    output logic [ID_W-1:0]          win_id,
    output logic [PRIO_W-1:0]        win_prio
);
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (!found || (prio[i] > win_prio))) begin
                found    = 1'b1;
                win_id   = ID_W'(i);
                win_prio = prio[i];
            end
        end
    end
endmodule

// File: rtl/irq_dispatch_ctrl.sv
// Interrupt dispatcher: sticky edge capture, priority selection with nested
// preemption against the in-service mask, valid/ack offer and EOI release.
module irq_dispatch_ctrl
    import irq_dispatch_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PRIO_W  = PRIO_W_DEF,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_in,
    irq_dispatch_ctrl_if.slave  bus,
    output logic [NUM_SRC-1:0]  in_service,
    output logic                irq_drop,
    output logic                eoi_err
);
    logic [NUM_SRC-1:0]             pending_reg, pending_next;
    logic [NUM_SRC-1:0]             in_service_reg, in_service_next;
    logic [NUM_SRC-1:0]             en_reg, irq_dly_reg;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_reg;
    state_t                         state_reg, state_next;
    logic                           valid_reg, valid_next;
    logic [ID_W-1:0]                id_reg, id_next;
    logic [PRIO_W-1:0]              oprio_reg, oprio_next;
    logic                           drop_reg, err_reg;

    logic [NUM_SRC-1:0] edge_vec, take_mask, eoi_hit, eoi_clr, eligible;
    logic               ack_take, eoi_bad, drop_now;
    logic               cur_active, sel_found;
    logic [PRIO_W-1:0]  cur_max, cur_prio, sel_prio;
    logic [ID_W-1:0]    sel_id, cur_id_unused;

    assign edge_vec = irq_in & ~irq_dly_reg & en_reg;
    assign ack_take = (state_reg == OFFER) && bus.irq_ack;

    irq_prio_select #(.N(NUM_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) u_cur_sel (
        .mask     (in_service_reg),
        .prio     (prio_reg),
        .found    (cur_active),
        .win_id   (cur_id_unused),
        .win_prio (cur_max)
    );

    assign cur_prio = cur_active ? cur_max : PRIO_W'(NONE_PRIO);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign take_mask[gi] = ack_take && (id_reg == ID_W'(gi));
            assign eoi_hit[gi]   = bus.eoi && (bus.eoi_id == ID_W'(gi));
            // Equal priority never preempts the running level.
            assign eligible[gi]  = pending_reg[gi] && en_reg[gi] && !in_service_reg[gi]
                                   && (!cur_active || (prio_reg[gi] > cur_prio));
        end
    endgenerate

    irq_prio_select #(.N(NUM_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) u_offer_sel (
        .mask     (eligible),
        .prio     (prio_reg),
        .found    (sel_found),
        .win_id   (sel_id),
        .win_prio (sel_prio)
    );

    assign eoi_clr         = eoi_hit & in_service_reg;
    assign eoi_bad         = bus.eoi && !(|eoi_clr);
    assign drop_now        = |(edge_vec & pending_reg);
    // A new edge beats the ack clear; the ack set beats the EOI clear.
    assign pending_next    = (pending_reg & ~take_mask) | edge_vec;
    assign in_service_next = (in_service_reg & ~eoi_clr) | take_mask;

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        id_next    = id_reg;
        oprio_next = oprio_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    valid_next = 1'b1;
                    id_next    = sel_id;
                    oprio_next = sel_prio;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (bus.irq_ack) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            valid_reg      <= 1'b0;
            id_reg         <= '0;
            oprio_reg      <= '0;
            pending_reg    <= '0;
            in_service_reg <= '0;
            en_reg         <= '0;
            prio_reg       <= '0;
            irq_dly_reg    <= '0;
            drop_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= valid_next;
            id_reg         <= id_next;
            oprio_reg      <= oprio_next;
            pending_reg    <= pending_next;
            in_service_reg <= in_service_next;
            irq_dly_reg    <= irq_in;
            drop_reg       <= drop_now;
            err_reg        <= eoi_bad;
            if (bus.cfg_we) begin
                prio_reg[bus.cfg_id] <= bus.cfg_prio;
                en_reg[bus.cfg_id]   <= bus.cfg_en;
            end
        end
    end

    assign bus.irq_valid = valid_reg;
    assign bus.irq_id    = id_reg;
    assign bus.irq_prio  = oprio_reg;
    assign in_service    = in_service_reg;
    assign irq_drop      = drop_reg;
    assign eoi_err       = err_reg;
endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Directed bench for irq_dispatch_ctrl: delivery, preemption, tie-break/hold,
// drop and EOI error pulses, simultaneous events and asynchronous reset.
module tb_irq_dispatch_ctrl;
    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] in_service;
    logic       irq_drop;
    logic       eoi_err;
    int         total;
    int         bad;

    irq_dispatch_ctrl_if bus ();

    irq_dispatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .bus        (bus),
        .in_service (in_service),
        .irq_drop   (irq_drop),
        .eoi_err    (eoi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cfg(input int id, input int prio, input logic en);
        bus.cfg_we   = 1'b1;
        bus.cfg_id   = 2'(id);
        bus.cfg_prio = 2'(prio);
        bus.cfg_en   = en;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] lines);
        irq_in = lines;
        tick();
        irq_in = 4'b0000;
    endtask

    task automatic do_ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic do_eoi(input int id);
        bus.eoi    = 1'b1;
        bus.eoi_id = 2'(id);
        tick();
        bus.eoi    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        irq_in = 4'b0000;
        bus.cfg_we = 1'b0; bus.cfg_id = '0; bus.cfg_prio = '0; bus.cfg_en = 1'b0;
        bus.irq_ack = 1'b0; bus.eoi = 1'b0; bus.eoi_id = '0;
        tick(); tick();
        chk("rst_valid", 32'(bus.irq_valid), 0);
        chk("rst_id", 32'(bus.irq_id), 0);
        chk("rst_prio", 32'(bus.irq_prio), 0);
        chk("rst_insvc", 32'(in_service), 0);
        chk("rst_drop", 32'(irq_drop), 0);
        chk("rst_err", 32'(eoi_err), 0);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) cfg(i, i, 1'b1);

        // Basic delivery of src1
        pulse(4'b0010);
        chk("basic_lat1", 32'(bus.irq_valid), 0);
        tick();
        chk("basic_valid", 32'(bus.irq_valid), 1);
        chk("basic_id", 32'(bus.irq_id), 1);
        chk("basic_prio", 32'(bus.irq_prio), 1);
        do_ack();
        chk("basic_insvc", 32'(in_service), 32'h2);
        chk("basic_drop_v", 32'(bus.irq_valid), 0);

        // Preemption: src0 blocked, src2 nests
        pulse(4'b0001); tick();
        chk("pre_low_block", 32'(bus.irq_valid), 0);
        pulse(4'b0100); tick();
        chk("pre_valid", 32'(bus.irq_valid), 1);
        chk("pre_id", 32'(bus.irq_id), 2);
        do_ack();
        chk("pre_insvc", 32'(in_service), 32'h6);
        tick();
        chk("pre_nest_idle", 32'(bus.irq_valid), 0);
        do_eoi(2);
        chk("eoi2_insvc", 32'(in_service), 32'h2);
        chk("eoi2_err", 32'(eoi_err), 0);
        tick();
        chk("eoi2_idle", 32'(bus.irq_valid), 0);
        do_eoi(1);
        chk("eoi1_insvc", 32'(in_service), 0);
        tick();
        chk("pre_src0_v", 32'(bus.irq_valid), 1);
        chk("pre_src0_id", 32'(bus.irq_id), 0);
        do_ack();
        do_eoi(0);
        chk("pre_clean", 32'(in_service), 0);

        // Tie-break and hold during offer
        cfg(1, 2, 1'b1);
        cfg(3, 2, 1'b1);
        pulse(4'b1010); tick();
        chk("tie_id", 32'(bus.irq_id), 1);
        chk("tie_prio", 32'(bus.irq_prio), 2);
        cfg(2, 3, 1'b1);
        pulse(4'b0100); tick();
        chk("hold_valid", 32'(bus.irq_valid), 1);
        chk("hold_id", 32'(bus.irq_id), 1);
        chk("hold_prio", 32'(bus.irq_prio), 2);
        do_ack();
        chk("tie_insvc", 32'(in_service), 32'h2);
        tick();
        chk("next_valid", 32'(bus.irq_valid), 1);
        chk("next_id", 32'(bus.irq_id), 2);
        chk("next_prio", 32'(bus.irq_prio), 3);
        do_ack();
        chk("next_insvc", 32'(in_service), 32'h6);
        do_eoi(2);
        do_eoi(1);
        tick();
        chk("src3_valid", 32'(bus.irq_valid), 1);
        chk("src3_id", 32'(bus.irq_id), 3);
        do_ack();
        do_eoi(3);
        chk("tie_clean", 32'(in_service), 0);

        // Drop and EOI error
        pulse(4'b0001);
        chk("drop_first", 32'(irq_drop), 0);
        tick();
        chk("drop_offer_id", 32'(bus.irq_id), 0);
        pulse(4'b0001);
        chk("drop_pulse", 32'(irq_drop), 1);
        tick();
        chk("drop_clear", 32'(irq_drop), 0);
        chk("drop_hold_v", 32'(bus.irq_valid), 1);
        do_eoi(3);
        chk("err_pulse", 32'(eoi_err), 1);
        chk("err_insvc", 32'(in_service), 0);
        tick();
        chk("err_clear", 32'(eoi_err), 0);
        chk("err_hold_id", 32'(bus.irq_id), 0);

        // Ack together with a new edge on the same source
        bus.irq_ack = 1'b1;
        irq_in = 4'b0001;
        tick();
        bus.irq_ack = 1'b0;
        irq_in = 4'b0000;
        chk("sim_insvc", 32'(in_service), 32'h1);
        chk("sim_valid", 32'(bus.irq_valid), 0);
        tick();
        chk("sim_blocked", 32'(bus.irq_valid), 0);
        do_eoi(0);
        chk("sim_eoi", 32'(in_service), 0);
        tick();
        chk("sim_reoffer_v", 32'(bus.irq_valid), 1);
        chk("sim_reoffer_id", 32'(bus.irq_id), 0);

        // Ack and EOI on the same id
        bus.irq_ack = 1'b1;
        bus.eoi = 1'b1;
        bus.eoi_id = 2'd0;
        tick();
        bus.irq_ack = 1'b0;
        bus.eoi = 1'b0;
        chk("ackeoi_insvc", 32'(in_service), 32'h1);
        chk("ackeoi_err", 32'(eoi_err), 1);

        // Asynchronous reset mid-offer
        pulse(4'b1000); tick();
        chk("arst_pre_v", 32'(bus.irq_valid), 1);
        chk("arst_pre_id", 32'(bus.irq_id), 3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.irq_valid), 0);
        chk("arst_insvc", 32'(in_service), 0);
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("post_idle", 32'(bus.irq_valid), 0);
        cfg(1, 1, 1'b1);
        pulse(4'b0010); tick();
        chk("rec_valid", 32'(bus.irq_valid), 1);
        chk("rec_id", 32'(bus.irq_id), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
